// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction prefetch queue between instruction memory
// and the IF/ID register. It issues sequential word fetches ahead of decode
// and buffers returned words with their PCs in a DEPTH-entry FIFO. It also
// drops stale in-flight responses after a redirect.
//
// Ports:
//   clk, reset_n            clock; synchronous active-low reset
//   mem_req_valid/ready     fetch request handshake; mem_req_addr = fetch PC
//   mem_rsp_valid/data      in-order responses, no backpressure
//   flush, flush_pc         redirect from EX; flush_pc[1:0] ignored
//   out_valid/ready         head-of-queue handshake toward decode
//   out_pc, out_instr       head entry fields
//   occupancy               FIFO entry count
//   perf_*_cnt              saturating event counters, only present when
//                           IF_PREFETCH_PERF_EN is defined
//
// Configuration macro: IF_PREFETCH_PERF_EN adds the performance counters.
module if_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]              perf_flush_cnt,
  output logic [31:0]              perf_drop_cnt,
  output logic [31:0]              perf_starve_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = OCC_W + CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] live_q, live_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [31:0]      pc_mem_q [DEPTH];
  logic [31:0]      pc_mem_d [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic             post_rst_q, post_rst_d;

  logic [SUM_W-1:0] slot_sum;
  logic [SUM_W-1:0] credit_sum;
  logic             req_acc;
  logic             rsp_drop;
  logic             rsp_live;
  logic             pop;
  logic [31:0]      flush_pc_aligned;
  logic             unused_flush_lsb;

  // Slots are reserved at issue, so a live response always finds room.
  assign slot_sum   = SUM_W'(count_q) + SUM_W'(live_q);
  assign credit_sum = SUM_W'(live_q) + SUM_W'(drop_q);

  assign mem_req_valid = reset_n && !flush &&
                         (slot_sum < SUM_W'(DEPTH)) &&
                         (credit_sum < SUM_W'(MAX_OUTSTANDING));
  assign mem_req_addr  = fetch_pc_q;
  assign req_acc       = mem_req_valid && mem_req_ready;

  // Stale responses are consumed first; responses with no credit are ignored.
  assign rsp_drop = mem_rsp_valid && (drop_q != '0);
  assign rsp_live = mem_rsp_valid && (drop_q == '0) && (live_q != '0);

  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign pop       = out_valid && out_ready;

  assign flush_pc_aligned = {flush_pc[31:2], 2'b00};
  assign unused_flush_lsb = ^flush_pc[1:0];

  // Next-state: fetch/response PCs, FIFO pointers and storage, credit counters.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    live_d      = live_q;
    drop_d      = drop_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    post_rst_d  = 1'b0;

    if (req_acc) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (rsp_live) begin
      pc_mem_d[wr_ptr_q]    = rsp_pc_q;
      instr_mem_d[wr_ptr_q] = mem_rsp_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      rsp_pc_d              = rsp_pc_q + 32'd4;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + OCC_W'(rsp_live) - OCC_W'(pop);
    live_d  = live_q + CNT_W'(req_acc) - CNT_W'(rsp_live);
    drop_d  = drop_q - CNT_W'(rsp_drop);

    // Redirect: every request still in flight becomes a response to drop.
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = flush_pc_aligned;
      rsp_pc_d   = flush_pc_aligned;
      live_d     = '0;
      drop_d     = drop_q + live_q + CNT_W'(req_acc) - CNT_W'(rsp_drop | rsp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      live_q      <= '0;
      drop_q      <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
      post_rst_q  <= 1'b1;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      live_q      <= live_d;
      drop_q      <= drop_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      post_rst_q  <= post_rst_d;
    end
  end

  // Responses in the first cycle after reset may belong to pre-reset requests.
  always_ff @(posedge clk) begin
    if (reset_n && !post_rst_q) begin
      assert (!(mem_rsp_valid && (live_q == '0) && (drop_q == '0)))
        else $error("if_prefetch_queue: response with no request outstanding");
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_drop_q, perf_drop_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  // Saturating event counters; a live response hit by a flush counts as dropped.
  always_comb begin
    perf_flush_d  = perf_flush_q;
    perf_drop_d   = perf_drop_q;
    perf_starve_d = perf_starve_q;
    if (flush && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
    if ((rsp_drop || (flush && rsp_live)) && (perf_drop_q != '1)) begin
      perf_drop_d = perf_drop_q + 32'd1;
    end
    if (out_ready && !out_valid && (perf_starve_q != '1)) begin
      perf_starve_d = perf_starve_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_flush_q  <= '0;
      perf_drop_q   <= '0;
      perf_starve_q <= '0;
    end else begin
      perf_flush_q  <= perf_flush_d;
      perf_drop_q   <= perf_drop_d;
      perf_starve_q <= perf_starve_d;
    end
  end

  assign perf_flush_cnt  = perf_flush_q;
  assign perf_drop_cnt   = perf_drop_q;
  assign perf_starve_cnt = perf_starve_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: 1-cycle in-order memory model with
// hold and stray-response injection, linear stimulus, immediate assertions.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_drop_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  logic        hold;
  logic        stray;
  logic        mem_clr;
  logic [31:0] pend [$];

  if_prefetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .flush(flush),
    .flush_pc(flush_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .occupancy(occupancy)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_flush_cnt(perf_flush_cnt),
    .perf_drop_cnt(perf_drop_cnt),
    .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: requests seen before a rising edge are answered in the next cycle.
  always @(negedge clk) begin
    if (mem_clr) begin
      pend.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end else if (stray) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hBAD0_BAD0;
    end else if (!hold && (pend.size() > 0)) begin
      mem_rsp_data  = mdata(pend.pop_front());
      mem_rsp_valid = 1'b1;
    end else begin
      mem_rsp_valid = 1'b0;
    end
    if (!mem_clr && reset_n && mem_req_valid && mem_req_ready) begin
      pend.push_back(mem_req_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'h0);
    chk({tag, "_req_addr"}, mem_req_addr, 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_occ"}, 32'(occupancy), 32'h0);
  endtask

  initial begin
    reset_n       = 1'b0;
    mem_req_ready = 1'b1;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    out_ready     = 1'b0;
    hold          = 1'b0;
    stray         = 1'b0;
    mem_clr       = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;

    // Reset values, then fill with decode stalled.
    step();
    step();
    chk_reset_outputs("rst0");
    reset_n = 1'b1;
    mem_clr = 1'b0;
    #1;
    chk("c0_req_valid", 32'(mem_req_valid), 32'h1);
    chk("c0_req_addr", mem_req_addr, 32'h0);
    step();
    chk("c1_req_addr", mem_req_addr, 32'h4);
    chk("c1_out_valid", 32'(out_valid), 32'h0);
    step();
    chk("c2_out_valid", 32'(out_valid), 32'h1);
    chk("c2_out_pc", out_pc, 32'h0);
    chk("c2_out_instr", out_instr, mdata(32'h0));
    chk("c2_req_addr", mem_req_addr, 32'h8);
    chk("c2_occ", 32'(occupancy), 32'h1);
    step();
    chk("c3_occ", 32'(occupancy), 32'h2);
    chk("c3_req_addr", mem_req_addr, 32'hC);
    step();
    chk("c4_occ", 32'(occupancy), 32'h3);
    chk("c4_req_valid", 32'(mem_req_valid), 32'h0);
    step();
    chk("c5_occ", 32'(occupancy), 32'h4);
    chk("c5_req_valid", 32'(mem_req_valid), 32'h0);
    step();
    chk("c6_occ", 32'(occupancy), 32'h4);
    chk("c6_req_valid", 32'(mem_req_valid), 32'h0);

    // Drain in order and keep streaming with push and pop every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("stream_out_pc", out_pc, 32'(4 * i));
      chk("stream_out_instr", out_instr, mdata(32'(4 * i)));
      if (i >= 2) chk("stream_occ", 32'(occupancy), 32'h2);
      step();
    end

    // Flush at restart, then flush with two requests in flight.
    reset_n = 1'b0;
    mem_clr = 1'b1;
    hold    = 1'b1;
    step();
    step();
    reset_n  = 1'b1;
    mem_clr  = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h10;
    #1;
    chk("f0_req_valid", 32'(mem_req_valid), 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("f1_req_valid", 32'(mem_req_valid), 32'h1);
    chk("f1_req_addr", mem_req_addr, 32'h10);
    step();
    chk("f2_req_addr", mem_req_addr, 32'h14);
    step();
    chk("f3_credit_req_valid", 32'(mem_req_valid), 32'h0);
    flush    = 1'b1;
    flush_pc = 32'h203;
    #1;
    chk("f3_flush_req_valid", 32'(mem_req_valid), 32'h0);
    step();
    flush = 1'b0;
    hold  = 1'b0;
    #1;
    chk("f4_drop_credit_req_valid", 32'(mem_req_valid), 32'h0);
    chk("f4_out_valid", 32'(out_valid), 32'h0);
    step();
    chk("f5_out_valid", 32'(out_valid), 32'h0);
    chk("f5_req_addr", mem_req_addr, 32'h200);
    step();
    chk("f6_out_valid", 32'(out_valid), 32'h0);
    chk("f6_req_addr", mem_req_addr, 32'h204);
    step();
    chk("f7_out_valid", 32'(out_valid), 32'h1);
    chk("f7_out_pc", out_pc, 32'h200);
    chk("f7_out_instr", out_instr, mdata(32'h200));
`ifdef IF_PREFETCH_PERF_EN
    chk("f7_perf_flush", perf_flush_cnt, 32'h2);
    chk("f7_perf_drop", perf_drop_cnt, 32'h2);
`endif
    step();
    chk("f8_out_pc", out_pc, 32'h204);
    chk("f8_out_instr", out_instr, mdata(32'h204));
    chk("f8_req_valid", 32'(mem_req_valid), 32'h1);

    // Flush in the same cycle as a live response and a pop.
    flush    = 1'b1;
    flush_pc = 32'h300;
    #1;
    chk("f8_flush_req_valid", 32'(mem_req_valid), 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("f9_out_valid", 32'(out_valid), 32'h0);
    chk("f9_occ", 32'(occupancy), 32'h0);
    chk("f9_req_addr", mem_req_addr, 32'h300);
    step();
    chk("f10_req_addr", mem_req_addr, 32'h304);
    chk("f10_out_valid", 32'(out_valid), 32'h0);
    step();
    chk("f11_out_pc", out_pc, 32'h300);
    chk("f11_out_instr", out_instr, mdata(32'h300));
    step();
    chk("f12_out_pc", out_pc, 32'h304);
    chk("f12_out_instr", out_instr, mdata(32'h304));

    // Two requests outstanding, then reset mid-stream.
    hold = 1'b1;
    step();
    chk("h13_req_valid", 32'(mem_req_valid), 32'h0);
    chk("h13_out_valid", 32'(out_valid), 32'h0);
    reset_n = 1'b0;
    mem_clr = 1'b1;
    step();
    step();
    chk_reset_outputs("rst1");
    reset_n = 1'b1;
    mem_clr = 1'b0;
    hold    = 1'b0;
    stray   = 1'b1;
    #1;
    chk("r0_req_valid", 32'(mem_req_valid), 32'h1);
    chk("r0_req_addr", mem_req_addr, 32'h0);
    step();
    stray = 1'b0;
    chk("r1_req_addr", mem_req_addr, 32'h4);
    chk("r1_out_valid", 32'(out_valid), 32'h0);
    step();
    chk("r2_out_pc", out_pc, 32'h0);
    chk("r2_out_instr", out_instr, mdata(32'h0));
    chk("r2_occ", 32'(occupancy), 32'h1);
    step();
    chk("r3_out_pc", out_pc, 32'h4);
    chk("r3_out_instr", out_instr, mdata(32'h4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
